// File: rtl/mem_access_pkg.sv
// Shared types and lane helpers for the CPU-side data memory access unit.
// Little-endian lanes: the byte at address offset k lives in data bits [8k+7:8k].
package mem_access_pkg;

   typedef enum logic [2:0] {
      LB  = 3'd0,
      LBU = 3'd1,
      LH  = 3'd2,
      LHU = 3'd3,
      LW  = 3'd4,
      SB  = 3'd5,
      SH  = 3'd6,
      SW  = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_RDATA,
      S_RESP
   } state_e;

   function automatic logic is_load(op_e op);
      return (op inside {LB, LBU, LH, LHU, LW});
   endfunction

   // Any encoding outside the known set is reported as a fault as well.
   function automatic logic is_misaligned(op_e op, logic [1:0] off);
      case (op)
         LB, LBU, SB: return 1'b0;
         LH, LHU, SH: return off[0];
         LW, SW:      return (off != 2'b00);
         default:     return 1'b1;
      endcase
   endfunction

   // Halfword selection looks only at off[1], so an unchecked odd offset
   // falls back to the enclosing aligned halfword.
   function automatic logic [3:0] byteenable_for(op_e op, logic [1:0] off);
      case (op)
         LB, LBU, SB: return 4'b0001 << off;
         LH, LHU, SH: return off[1] ? 4'b1100 : 4'b0011;
         LW, SW:      return 4'b1111;
         default:     return 4'b0000;
      endcase
   endfunction

   function automatic logic [31:0] extend_load(op_e op, logic [1:0] off, logic [31:0] rdata);
      logic signed [7:0]  sbyte;
      logic signed [15:0] shalf;
      sbyte = rdata[8*off +: 8];
      shalf = off[1] ? rdata[31:16] : rdata[15:0];
      case (op)
         LB:      return 32'(sbyte);
         LBU:     return {24'h0, sbyte};
         LH:      return 32'(shalf);
         LHU:     return {16'h0, shalf};
         LW:      return rdata;
         default: return 32'h0;
      endcase
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: byte enables and replicated store data for the
// write path, lane extraction and extension for the read path.
module mem_lane_align
   import mem_access_pkg::*;
(
   input  logic [2:0]  op,
   input  logic [1:0]  off,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  byteenable,
   output logic [31:0] wdata_lane,
   output logic [31:0] rdata_ext
);

   op_e op_t;

   assign op_t       = op_e'(op);
   assign byteenable = byteenable_for(op_t, off);
   assign rdata_ext  = extend_load(op_t, off, rdata);

   always_comb begin
      wdata_lane = wdata;
      case (op_t)
         SB:      wdata_lane = {4{wdata[7:0]}};
         SH:      wdata_lane = {2{wdata[15:0]}};
         default: wdata_lane = wdata;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store initiator for the byte-enabled 32-bit data memory.
// Accepts one request in IDLE, issues it, waits out waitrequest and returns one response pulse.
module mem_access_unit
   import mem_access_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter bit CHECK_ALIGN = 1'b1
)
(
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [2:0]        req_op,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_fault,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_read,
   output logic              mem_write,
   output logic [3:0]        mem_byteenable,
   output logic [31:0]       mem_writedata,
   input  logic              mem_waitrequest,
   input  logic [31:0]       mem_readdata
);

   state_e      state;
   state_e      state_next;
   op_e         req_op_t;
   op_e         op_q;
   logic [1:0]  off_q;
   logic        fault_now;
   logic        in_idle;

   logic [2:0]  align_op;
   logic [1:0]  align_off;
   logic [3:0]  align_be;
   logic [31:0] align_wd;
   logic [31:0] align_rd;

   assign req_op_t  = op_e'(req_op);
   assign in_idle   = (state == S_IDLE);
   assign fault_now = CHECK_ALIGN && is_misaligned(req_op_t, req_addr[1:0]);

   // One lane block serves both directions: in IDLE it sees the incoming
   // request (write path), afterwards the captured op/offset (read path).
   assign align_op  = in_idle ? req_op        : op_q;
   assign align_off = in_idle ? req_addr[1:0] : off_q;

   mem_lane_align u_align (
      .op         (align_op),
      .off        (align_off),
      .wdata      (req_wdata),
      .rdata      (mem_readdata),
      .byteenable (align_be),
      .wdata_lane (align_wd),
      .rdata_ext  (align_rd)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE: begin
            if (req_valid) begin
               state_next = fault_now ? S_RESP : S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (!mem_waitrequest) begin
               state_next = is_load(op_q) ? S_RDATA : S_RESP;
            end
         end
         S_RDATA: state_next = S_RESP;
         S_RESP:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (in_idle && req_valid) begin
         op_q  <= req_op_t;
         off_q <= req_addr[1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         req_ready      <= 1'b1;
         resp_valid     <= 1'b0;
         resp_rdata     <= 32'h0;
         resp_fault     <= 1'b0;
         mem_read       <= 1'b0;
         mem_write      <= 1'b0;
         mem_address    <= '0;
         mem_byteenable <= 4'h0;
         mem_writedata  <= 32'h0;
      end else begin
         req_ready  <= (state_next == S_IDLE);
         resp_valid <= (state_next == S_RESP);
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  if (fault_now) begin
                     resp_fault <= 1'b1;
                     resp_rdata <= 32'h0;
                  end else begin
                     resp_fault     <= 1'b0;
                     mem_read       <= is_load(req_op_t);
                     mem_write      <= !is_load(req_op_t);
                     mem_address    <= {req_addr[ADDR_W-1:2], 2'b00};
                     mem_byteenable <= align_be;
                     mem_writedata  <= align_wd;
                  end
               end
            end
            // Strobes drop only once the memory has taken the access.
            S_ISSUE: begin
               if (!mem_waitrequest) begin
                  mem_read   <= 1'b0;
                  mem_write  <= 1'b0;
                  resp_fault <= 1'b0;
                  resp_rdata <= 32'h0;
               end
            end
            S_RDATA: resp_rdata <= align_rd;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, randomized transactions
// against a behavioural model, and a reset-during-wait sequence.
module tb_mem_access_unit;
   import mem_access_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_op;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_fault;
   logic [31:0] mem_address;
   logic        mem_read;
   logic        mem_write;
   logic [3:0]  mem_byteenable;
   logic [31:0] mem_writedata;
   logic        mem_waitrequest;
   logic [31:0] mem_readdata;

   always #5 clk = ~clk;

   mem_access_unit #(.ADDR_W(32), .CHECK_ALIGN(1'b1)) dut (
      .clk             (clk),
      .reset           (reset),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_op          (req_op),
      .req_addr        (req_addr),
      .req_wdata       (req_wdata),
      .resp_valid      (resp_valid),
      .resp_rdata      (resp_rdata),
      .resp_fault      (resp_fault),
      .mem_address     (mem_address),
      .mem_read        (mem_read),
      .mem_write       (mem_write),
      .mem_byteenable  (mem_byteenable),
      .mem_writedata   (mem_writedata),
      .mem_waitrequest (mem_waitrequest),
      .mem_readdata    (mem_readdata)
   );

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
   endtask

   // ---------------- behavioural reference ----------------
   function automatic bit m_is_load(logic [2:0] op);
      return op <= 3'd4;
   endfunction

   function automatic bit m_fault(logic [2:0] op, logic [31:0] addr);
      int k = int'(addr[1:0]);
      if (op == LH || op == LHU || op == SH) return (k % 2) != 0;
      if (op == LW || op == SW) return k != 0;
      return 1'b0;
   endfunction

   function automatic logic [3:0] m_be(logic [2:0] op, logic [31:0] addr);
      int k = int'(addr[1:0]);
      if (op == LB || op == LBU || op == SB) return 4'(1 << k);
      if (op == LH || op == LHU || op == SH) return 4'(3 << (2 * (k / 2)));
      return 4'hF;
   endfunction

   function automatic logic [31:0] m_wd(logic [2:0] op, logic [31:0] wdata);
      if (op == SB) return 32'h01010101 * {24'h0, wdata[7:0]};
      if (op == SH) return 32'h00010001 * {16'h0, wdata[15:0]};
      return wdata;
   endfunction

   function automatic logic [31:0] m_load(logic [2:0] op, logic [31:0] addr, logic [31:0] rdata);
      int k = int'(addr[1:0]);
      logic [31:0] v;
      case (op)
         LB, LBU: begin
            v = (rdata >> (8 * k)) & 32'hFF;
            if (op == LB && v >= 32'h80) v = v + 32'hFFFFFF00;
         end
         LH, LHU: begin
            v = (rdata >> (16 * (k / 2))) & 32'hFFFF;
            if (op == LH && v >= 32'h8000) v = v + 32'hFFFF0000;
         end
         default: v = rdata;
      endcase
      return v;
   endfunction

   // ---------------- transaction driver / observer ----------------
   int          o_resp_cyc, o_first, o_strobes;
   logic [31:0] o_rdata, o_wd, o_addr;
   logic [3:0]  o_be;
   logic        o_fault, o_rd, o_wr, o_both, o_stable, o_after_valid, o_after_ready;

   // Starts in an IDLE cycle (post-edge); ends one cycle after the response.
   task automatic run_txn(logic [2:0] op, logic [31:0] addr, logic [31:0] wdata,
                          logic [31:0] rdata, int waits);
      int          wcnt = 0;
      bit          acc_prev = 0;
      logic        prev_strobe = 0, prev_wait = 0;
      logic [69:0] prev_mem = '0;
      o_resp_cyc = -1; o_first = -1; o_strobes = 0;
      o_rdata = '0; o_wd = '0; o_addr = '0; o_be = '0;
      o_fault = 0; o_rd = 0; o_wr = 0; o_both = 0; o_stable = 1;
      req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
      mem_waitrequest = 1'b0; mem_readdata = $urandom;
      for (int cyc = 1; cyc <= 30; cyc++) begin
         @(posedge clk); #1;
         req_valid = 1'($urandom_range(0, 1));
         req_op = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
         if (mem_read && mem_write) o_both = 1;
         if (mem_read || mem_write) begin
            if (o_first < 0) begin
               o_first = cyc; o_rd = mem_read; o_wr = mem_write;
               o_addr = mem_address; o_be = mem_byteenable; o_wd = mem_writedata;
            end
            o_strobes++;
         end
         if (prev_strobe && prev_wait &&
             {mem_read, mem_write, mem_address, mem_byteenable, mem_writedata} != prev_mem)
            o_stable = 0;
         mem_readdata = acc_prev ? rdata : $urandom;
         acc_prev = 0;
         if (mem_read || mem_write) begin
            if (wcnt < waits) begin
               mem_waitrequest = 1'b1; wcnt++;
            end else begin
               mem_waitrequest = 1'b0; acc_prev = mem_read;
            end
         end else begin
            mem_waitrequest = 1'b0;
         end
         prev_strobe = mem_read || mem_write;
         prev_wait   = mem_waitrequest;
         prev_mem    = {mem_read, mem_write, mem_address, mem_byteenable, mem_writedata};
         if (resp_valid) begin
            o_resp_cyc = cyc; o_rdata = resp_rdata; o_fault = resp_fault;
            req_valid = 1'b0;
            break;
         end
      end
      req_valid = 1'b0;
      mem_waitrequest = 1'b0;
      @(posedge clk); #1;
      o_after_valid = resp_valid;
      o_after_ready = req_ready;
   endtask

   task automatic verify(string nm, logic [2:0] op, logic [31:0] addr, int waits,
                         logic fault, logic [3:0] be, logic [31:0] wd, logic [31:0] rd);
      bit ld = m_is_load(op);
      int exp_cyc = fault ? 1 : (ld ? 3 + waits : 2 + waits);
      check({nm, " resp_cycle"}, 32'(o_resp_cyc), 32'(exp_cyc));
      check({nm, " resp_fault"}, {31'h0, o_fault}, {31'h0, fault});
      check({nm, " resp_rdata"}, o_rdata, rd);
      check({nm, " one_pulse"}, {31'h0, o_after_valid}, 32'h0);
      check({nm, " ready_after"}, {31'h0, o_after_ready}, 32'h1);
      check({nm, " rd_wr_exclusive"}, {31'h0, o_both}, 32'h0);
      if (fault) begin
         check({nm, " no_strobe"}, 32'(o_strobes), 32'h0);
      end else begin
         check({nm, " strobe_cycle"}, 32'(o_first), 32'h1);
         check({nm, " strobe_len"}, 32'(o_strobes), 32'(waits + 1));
         check({nm, " mem_read"}, {31'h0, o_rd}, {31'h0, ld});
         check({nm, " mem_write"}, {31'h0, o_wr}, {31'h0, !ld});
         check({nm, " mem_address"}, o_addr, addr & 32'hFFFFFFFC);
         check({nm, " byteenable"}, {28'h0, o_be}, {28'h0, be});
         check({nm, " held_in_wait"}, {31'h0, o_stable}, 32'h1);
         if (!ld) check({nm, " writedata"}, o_wd, wd);
      end
   endtask

   typedef struct {
      logic [2:0]  op;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          waits;
      logic [3:0]  be;
      logic [31:0] wd;
      logic [31:0] rd;
      logic        fault;
   } vec_t;

   vec_t tbl[12];

   initial begin
      int resp_seen;
      tbl[0]  = '{SW,  32'hBFC00010, 32'hDEADBEEF, 32'h0,        0, 4'hF, 32'hDEADBEEF, 32'h0,        1'b0};
      tbl[1]  = '{SB,  32'h00000103, 32'h000000A5, 32'h0,        0, 4'h8, 32'hA5A5A5A5, 32'h0,        1'b0};
      tbl[2]  = '{SH,  32'h00000102, 32'h1234BEEF, 32'h0,        0, 4'hC, 32'hBEEFBEEF, 32'h0,        1'b0};
      tbl[3]  = '{LB,  32'h00000102, 32'h0,        32'h11802233, 0, 4'h4, 32'h0,        32'hFFFFFF80, 1'b0};
      tbl[4]  = '{LBU, 32'h00000102, 32'h0,        32'h11802233, 0, 4'h4, 32'h0,        32'h00000080, 1'b0};
      tbl[5]  = '{LHU, 32'h00000100, 32'h0,        32'h11802233, 0, 4'h3, 32'h0,        32'h00002233, 1'b0};
      tbl[6]  = '{LW,  32'h00000200, 32'h0,        32'hCAFEF00D, 3, 4'hF, 32'h0,        32'hCAFEF00D, 1'b0};
      tbl[7]  = '{LH,  32'h00000101, 32'h0,        32'h11802233, 0, 4'h0, 32'h0,        32'h0,        1'b1};
      tbl[8]  = '{LH,  32'h00000102, 32'h0,        32'h11802233, 0, 4'hC, 32'h0,        32'h00001180, 1'b0};
      tbl[9]  = '{LH,  32'h00000100, 32'h0,        32'h00008001, 0, 4'h3, 32'h0,        32'hFFFF8001, 1'b0};
      tbl[10] = '{SW,  32'h00000102, 32'h55667788, 32'h0,        0, 4'h0, 32'h0,        32'h0,        1'b1};
      tbl[11] = '{LB,  32'h00000103, 32'h0,        32'h7F000000, 1, 4'h8, 32'h0,        32'h0000007F, 1'b0};

      reset = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_addr = '0; req_wdata = '0;
      mem_waitrequest = 1'b0; mem_readdata = '0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      check("reset req_ready", {31'h0, req_ready}, 32'h1);
      check("reset resp_valid", {31'h0, resp_valid}, 32'h0);
      check("reset resp_rdata", resp_rdata, 32'h0);
      check("reset resp_fault", {31'h0, resp_fault}, 32'h0);
      check("reset strobes", {30'h0, mem_read, mem_write}, 32'h0);
      check("reset mem_address", mem_address, 32'h0);
      check("reset byteenable", {28'h0, mem_byteenable}, 32'h0);
      check("reset writedata", mem_writedata, 32'h0);

      for (int i = 0; i < 12; i++) begin
         run_txn(tbl[i].op, tbl[i].addr, tbl[i].wdata, tbl[i].rdata, tbl[i].waits);
         verify($sformatf("vec%0d", i), tbl[i].op, tbl[i].addr, tbl[i].waits,
                tbl[i].fault, tbl[i].be, tbl[i].wd, tbl[i].rd);
      end

      for (int i = 0; i < 150; i++) begin
         logic [2:0]  op    = 3'($urandom);
         logic [31:0] addr  = $urandom;
         logic [31:0] wdata = $urandom;
         logic [31:0] rdata = $urandom;
         int          waits = $urandom_range(0, 2);
         bit          f     = m_fault(op, addr);
         run_txn(op, addr, wdata, rdata, waits);
         verify($sformatf("rnd%0d", i), op, addr, waits, f, m_be(op, addr),
                m_wd(op, wdata), (m_is_load(op) && !f) ? m_load(op, addr, rdata) : 32'h0);
      end

      // Reset while a load is stalled in waitrequest.
      req_valid = 1'b1; req_op = LW; req_addr = 32'h00000300; req_wdata = '0;
      @(posedge clk); #1;
      req_valid = 1'b0;
      check("abort mem_read_c1", {31'h0, mem_read}, 32'h1);
      mem_waitrequest = 1'b1;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      mem_waitrequest = 1'b0;
      check("abort mem_read_c3", {31'h0, mem_read}, 32'h0);
      check("abort mem_write_c3", {31'h0, mem_write}, 32'h0);
      check("abort req_ready_c3", {31'h0, req_ready}, 32'h1);
      resp_seen = resp_valid ? 1 : 0;
      repeat (6) begin
         @(posedge clk); #1;
         if (resp_valid) resp_seen++;
      end
      check("abort no_resp", 32'(resp_seen), 32'h0);
      run_txn(SW, 32'h00000400, 32'h0BADF00D, 32'h0, 0);
      verify("post_reset_sw", SW, 32'h00000400, 0, 1'b0, 4'hF, 32'h0BADF00D, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- CPU-side initiator for the byte-enabled 32-bit data memory.
- Accepts one load/store request at a time from the execute/memory stage and derives the word-aligned address, byte enables and lane-shifted write data.
- Issues the access, waits out mem_waitrequest, then captures the registered read data one cycle later.
- Returns sign- or zero-extended load results to the register-writeback path.

Parameters:
- ADDR_W, 32, byte-address width on both the CPU and memory sides.
- CHECK_ALIGN, 1, when 1 a misaligned halfword or word request faults without any memory access; when 0 the low address bits are ignored for H/W accesses.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request (state IDLE).
- req_op  in  3  LB/LBU/LH/LHU/LW/SB/SH/SW (package encoding).
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store source; the low byte or halfword is significant for SB/SH.
- resp_valid  out  1  one-cycle pulse: load result or store completion.
- resp_rdata  out  32  extended load result; 0 for stores and faults.
- resp_fault  out  1  qualifies resp_valid: misaligned access.
- mem_address  out  ADDR_W  word address (req_addr with bits [1:0] forced to 0).
- mem_read  out  1  read strobe.
- mem_write  out  1  write strobe.
- mem_byteenable  out  4  bit k enables data bits [8k+7:8k].
- mem_writedata  out  32  lane-aligned store data.
- mem_waitrequest  in  1  memory stall; hold all mem_* outputs while high.
- mem_readdata  in  32  valid on the cycle after a read is accepted.

Behaviour:
- Byte lanes are little-endian: a byte at address offset k = addr[1:0] lives in lane k.
- Byte enables:
  - Byte ops: 1<<k.
  - Halfword ops: 4'b0011 when k=0, 4'b1100 when k=2.
  - Word ops: 4'b1111.
- Store data: SB replicates wdata[7:0] to all four lanes; SH replicates wdata[15:0] to both halves; SW passes wdata unchanged.
- Load extraction: select the lane(s) by the registered k. LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_fault=0, mem_read=0, mem_write=0, mem_address=0, mem_byteenable=0, mem_writedata=0.
- All outputs are registered.
- FSM states:
  - IDLE: req_ready=1. On req_valid, register op, address and data.
    - Misaligned (CHECK_ALIGN=1; H with addr[0]=1, or W with addr[1:0]≠0) -> RESP with fault=1.
    - Otherwise -> ISSUE, asserting mem_read or mem_write and driving the derived signals from the next cycle.
  - ISSUE: hold all mem_* stable while mem_waitrequest=1.
    - When mem_waitrequest=0 the access is accepted that cycle: drop the strobes next cycle.
    - Store -> RESP; load -> RDATA.
  - RDATA: sample mem_readdata, extract and extend it -> RESP.
  - RESP: resp_valid=1 for exactly one cycle -> IDLE. req_ready stays low; there is no back-to-back acceptance in RESP.
- Latency with no wait states, counted from the req_valid&req_ready cycle (cycle 0):
  - Store: mem_write high in cycle 1, resp_valid in cycle 2.
  - Load: mem_read high in cycle 1, data sampled in cycle 2, resp_valid in cycle 3.
  - Misaligned: resp_valid in cycle 1.
- Each cycle of waitrequest adds one cycle. mem_read and mem_write are never high together.
- Requests arriving while req_ready=0 are ignored; the source holds them.
- An undefined req_op encoding is treated as a misaligned fault.
- Reset in any state (including ISSUE mid-wait): next cycle is IDLE, strobes are low, and no resp_valid is produced for the aborted request.
- Address wrap: only bits [1:0] are masked. No arithmetic is done on the address, so no carry is possible.

Decomposition:
- Package mem_access_pkg holds:
  - the op enum (LB=0, LBU=1, LH=2, LHU=3, LW=4, SB=5, SH=6, SW=7);
  - the FSM state enum;
  - the helper functions is_load, is_misaligned, byteenable_for and extend_load.
- One natural sub-module, mem_lane_align: a combinational block computing byteenable, replicated write data and the extended read result from op, addr[1:0] and readdata. Instantiated once and reused for both the write and read paths.

Test Plan:
- SW addr=0xBFC00010 wdata=0xDEADBEEF, waitrequest=0 -> cycle 1: mem_write=1, mem_address=0xBFC00010, byteenable=4'b1111, writedata=0xDEADBEEF; cycle 2: resp_valid=1, fault=0.
- SB addr=0x00000103 wdata=0x000000A5 -> byteenable=4'b1000, writedata=0xA5A5A5A5.
- SH addr=0x00000102 wdata=0x1234BEEF -> byteenable=4'b1100, writedata=0xBEEFBEEF.
- LB addr=0x00000102, mem_readdata=0x11802233 -> resp_rdata=0xFFFFFF80 in cycle 3.
- LBU, same address and data -> resp_rdata=0x00000080.
- LHU addr=0x00000100 with the same data -> resp_rdata=0x00002233.
- LW with mem_waitrequest high for 3 cycles -> mem_read/address/byteenable held constant for 4 cycles; resp_valid in cycle 6 with resp_rdata equal to mem_readdata.
- LH addr=0x00000101 -> resp_valid with fault=1 in cycle 1; mem_read never asserted; resp_rdata=0.
- LW issued, waitrequest=1, reset pulsed in cycle 2 -> cycle 3: mem_read=0, req_ready=1, no resp_valid afterwards.
- Subsequent SW completes normally after that reset.
